alu_op_sequencer: RTL and testbench

Multi-cycle control sequencer in front of the combinational ALU. It accepts one operation request at a time over a valid/ready handshake and captures the operands. It drives the ALU's one-hot operation selects for a per-opcode number of settle cycles, then latches the ALU's low/high results into the Z register pair (zlo/zhi) and pulses done. It sits between the control unit and the ALU, replacing direct control-unit drive of the ALU selects.

---
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving one-hot ALU selects and latching results into Z.
// Optional macro DIV_ZERO_TRAP_EN: trap DIV with zero divisor and report dz_err.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [31:0] rb_in,
    input  logic [31:0] ry_in,
    output logic [31:0] alu_rb,
    output logic [31:0] alu_ry,
    output logic [12:0] alu_sel,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    output logic [31:0] zlo,
    output logic [31:0] zhi,
    output logic        done,
    output logic        bad_op
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic        dz_err
`endif
);

    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_LAST = 4'd12;
    localparam logic [7:0] MUL_LD  = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LD  = 8'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] rb_q, rb_d;
    logic [31:0] ry_q, ry_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] zlo_q, zlo_d;
    logic [31:0] zhi_q, zhi_d;
    logic        bad_q, bad_d;
    logic        skip;
`ifdef DIV_ZERO_TRAP_EN
    logic        dz_q, dz_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rb_d    = rb_q;
        ry_d    = ry_q;
        cnt_d   = cnt_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;
        bad_d   = bad_q;
        skip    = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d  = op_code;
                    rb_d  = rb_in;
                    ry_d  = ry_in;
                    bad_d = (op_code > OP_LAST);
                    skip  = bad_d;
`ifdef DIV_ZERO_TRAP_EN
                    dz_d  = (op_code == OP_DIV) && (ry_in == '0);
                    skip  = skip | dz_d;
`endif
                    if (op_code == OP_MUL)
                        cnt_d = MUL_LD;
                    else if (op_code == OP_DIV)
                        cnt_d = DIV_LD;
                    else
                        cnt_d = '0;
                    state_d = skip ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    zlo_d = alu_lo;
                    // Only the wide-result ops own the high half of Z
                    if (op_q == OP_MUL || op_q == OP_DIV)
                        zhi_d = alu_hi;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rb_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            bad_q   <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rb_q    <= rb_d;
            ry_q    <= ry_d;
            cnt_q   <= cnt_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            bad_q   <= bad_d;
`ifdef DIV_ZERO_TRAP_EN
            dz_q    <= dz_d;
`endif
        end
    end

    // EXEC is only entered with a legal opcode, so the shift stays in range
    assign alu_sel  = (state_q == S_EXEC) ? (13'd1 << op_q) : '0;
    assign op_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign bad_op   = done & bad_q;
    assign alu_rb   = rb_q;
    assign alu_ry   = ry_q;
    assign zlo      = zlo_q;
    assign zhi      = zhi_q;
`ifdef DIV_ZERO_TRAP_EN
    assign dz_err   = done & dz_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed steps plus random ops against a reference.
// Honours DIV_ZERO_TRAP_EN the same way as the design.
module tb_alu_op_sequencer;

    localparam int MULC = 2;
    localparam int DIVC = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] rb_in, ry_in;
    logic [31:0] alu_rb, alu_ry;
    logic [12:0] alu_sel;
    logic [31:0] alu_lo, alu_hi;
    logic [31:0] zlo, zhi;
    logic        done, bad_op;
`ifdef DIV_ZERO_TRAP_EN
    logic        dz_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] m_zlo, m_zhi;
    logic [63:0] alu_res;

    alu_op_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clock   (clock),
        .clear   (clear),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code (op_code),
        .rb_in   (rb_in),
        .ry_in   (ry_in),
        .alu_rb  (alu_rb),
        .alu_ry  (alu_ry),
        .alu_sel (alu_sel),
        .alu_lo  (alu_lo),
        .alu_hi  (alu_hi),
        .zlo     (zlo),
        .zhi     (zhi),
        .done    (done),
        .bad_op  (bad_op)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .dz_err  (dz_err)
`endif
    );

    always #5 clock = ~clock;

    // ALU behaviour: returns {hi, lo}
    function automatic logic [63:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] lo;
        logic [4:0]  s;
        s  = b[4:0];
        lo = 32'h0;
        case (op)
            4'd0:  lo = a & b;
            4'd1:  lo = a | b;
            4'd2:  lo = 32'h0 - b;
            4'd3:  lo = ~b;
            4'd4:  lo = a - b;
            4'd5:  lo = a + b;
            4'd6:  return {32'h0, a} * {32'h0, b};
            4'd7:  lo = (s == 0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
            4'd8:  lo = (s == 0) ? a : ((a << s) | (a >> (6'd32 - {1'b0, s})));
            4'd9:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd10: lo = a >> s;
            4'd11: lo = a << s;
            4'd12: lo = $signed(a) >>> s;
            default: lo = 32'h0;
        endcase
        return {lo ^ 32'hA5A5_5A5A, lo};
    endfunction

    always_comb begin
        alu_res = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 13; i++)
            if (alu_sel == (13'd1 << i))
                alu_res = alu_ref(4'(i), alu_rb, alu_ry);
    end
    assign alu_lo = alu_res[31:0];
    assign alu_hi = alu_res[63:32];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] rb,
                          input logic [31:0] ry, input bit perturb);
        int          n;
        bit          ill, trap;
        logic [63:0] r;
        logic [31:0] elo, ehi;
        logic [12:0] oh;
        ill  = (op > 4'd12);
        trap = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        trap = (op == 4'd9) && (ry == 0);
`endif
        if (ill || trap)    n = 0;
        else if (op == 4'd6) n = MULC;
        else if (op == 4'd9) n = DIVC;
        else                 n = 1;
        r = alu_ref(op, rb, ry);
        if (n > 0) begin
            elo = r[31:0];
            ehi = (op == 4'd6 || op == 4'd9) ? r[63:32] : m_zhi;
        end else begin
            elo = m_zlo;
            ehi = m_zhi;
        end
        oh = ill ? 13'h0 : (13'd1 << op);

        chk("ready_idle", op_ready, 1);
        op_valid = 1'b1;
        op_code  = op;
        rb_in    = rb;
        ry_in    = ry;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            chk("exec_sel", alu_sel, oh);
            chk("exec_ready", op_ready, 0);
            chk("exec_done", done, 0);
            chk("exec_rb", alu_rb, rb);
            chk("exec_ry", alu_ry, ry);
            chk("exec_zlo_hold", zlo, m_zlo);
            if (perturb) begin
                op_valid = k[0];
                op_code  = 4'd5;
                rb_in    = ~rb;
            end
            @(posedge clock);
            @(negedge clock);
        end
        chk("done", done, 1);
        chk("bad_op", bad_op, ill);
`ifdef DIV_ZERO_TRAP_EN
        chk("dz_err", dz_err, trap);
`endif
        chk("done_sel", alu_sel, 0);
        chk("done_ready", op_ready, 0);
        chk("zlo", zlo, elo);
        chk("zhi", zhi, ehi);
        op_valid = 1'b0;
        m_zlo = elo;
        m_zhi = ehi;
        @(posedge clock);
        @(negedge clock);
        chk("post_done", done, 0);
        chk("post_ready", op_ready, 1);
        chk("post_zlo", zlo, m_zlo);
    endtask

    initial begin
        clear    = 1'b0;
        op_valid = 1'b0;
        op_code  = 4'd0;
        rb_in    = 32'h0;
        ry_in    = 32'h0;
        m_zlo    = 32'h0;
        m_zhi    = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_bad", bad_op, 0);
        chk("rst_sel", alu_sel, 0);
        chk("rst_zlo", zlo, 0);
        chk("rst_zhi", zhi, 0);
        chk("rst_rb", alu_rb, 0);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);

        run_op(4'd5, 32'd5, 32'd7, 1'b0);
        run_op(4'd6, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op(4'd9, 32'd17, 32'd5, 1'b1);
        run_op(4'd14, 32'd1, 32'd2, 1'b0);
        run_op(4'd5, 32'h50, 32'h5, 1'b0);
        run_op(4'd9, 32'd99, 32'd0, 1'b0);

        // reset in the middle of a DIV: no Z write, no done
        run_op(4'd5, 32'h1234, 32'h1, 1'b0);
        op_valid = 1'b1;
        op_code  = 4'd9;
        rb_in    = 32'd100;
        ry_in    = 32'd3;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("clr_ready", op_ready, 1);
        chk("clr_done", done, 0);
        chk("clr_sel", alu_sel, 0);
        chk("clr_zlo", zlo, 0);
        chk("clr_zhi", zhi, 0);
        @(posedge clock);
        @(negedge clock);
        chk("clr_noaccept", op_ready, 1);
        clear    = 1'b1;
        op_valid = 1'b0;
        m_zlo    = 32'h0;
        m_zhi    = 32'h0;
        @(posedge clock);
        @(negedge clock);
        chk("clr_idle_ready", op_ready, 1);
        chk("clr_idle_done", done, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
